// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Sequential radix-2 multiply/divide unit with HI/LO result registers
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_data_A,
  input  logic [WIDTH-1:0] i_data_B,
  input  logic             i_hi_we,
  input  logic             i_lo_we,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_neg_res;
  logic             r_neg_rem;
  logic             r_dz;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_div_by_zero;

  logic               w_start;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_madd;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_dshift;
  logic [WIDTH:0]     w_ddiff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      IDLE: if (i_start) w_next = CALC;
      CALC: begin
        o_busy = 1'b1;
        if (r_cnt == '0) w_next = FIX;
      end
      FIX: begin
        o_busy = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        o_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand conditioning: signed ops run on magnitudes, signs re-applied in FIX
  // ---------------------------------------------------------------------------
  assign w_start  = (r_state == IDLE) && i_start;
  assign w_signed = SIGNED_EN && i_op[0];
  assign w_a_neg  = w_signed && i_data_A[WIDTH-1];
  assign w_b_neg  = w_signed && i_data_B[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (WIDTH'(0) - i_data_A) : i_data_A;
  assign w_b_mag  = w_b_neg ? (WIDTH'(0) - i_data_B) : i_data_B;

  // Multiply: {r_rem, r_q} is the product shift register, r_q starts as multiplier
  assign w_madd = r_q[0] ? r_op_b : '0;
  assign w_msum = {1'b0, r_rem} + {1'b0, w_madd};

  // Restoring divide: r_rem is the partial remainder, r_q shifts dividend out / quotient in
  assign w_dshift = {r_rem, r_q[WIDTH-1]};
  assign w_ddiff  = w_dshift - {1'b0, r_op_b};

  assign w_prod     = {r_rem, r_q};
  assign w_prod_fix = r_neg_res ? ((2*WIDTH)'(0) - w_prod) : w_prod;
  assign w_quot_fix = r_neg_res ? (WIDTH'(0) - r_q) : r_q;
  assign w_rem_fix  = r_neg_rem ? (WIDTH'(0) - r_rem) : r_rem;

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_is_div      <= 1'b0;
      r_neg_res     <= 1'b0;
      r_neg_rem     <= 1'b0;
      r_dz          <= 1'b0;
      r_op_b        <= '0;
      r_rem         <= '0;
      r_q           <= '0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_cnt         <= CNT_W'(WIDTH - 1);
            r_is_div      <= i_op[1];
            r_neg_res     <= w_a_neg ^ w_b_neg;
            r_neg_rem     <= w_a_neg;
            r_dz          <= i_op[1] && (i_data_B == '0);
            r_op_b        <= w_b_mag;
            r_rem         <= '0;
            r_q           <= w_a_mag;
            r_div_by_zero <= 1'b0;
          end else begin
            if (i_hi_we) r_hi <= i_data_A;
            if (i_lo_we) r_lo <= i_data_A;
          end
        end
        CALC: begin
          if (r_is_div) begin
            r_rem <= w_ddiff[WIDTH] ? w_dshift[WIDTH-1:0] : w_ddiff[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], ~w_ddiff[WIDTH]};
          end else begin
            r_rem <= w_msum[WIDTH:1];
            r_q   <= {w_msum[0], r_q[WIDTH-1:1]};
          end
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        FIX: begin
          // A zero divisor leaves |A| in the remainder, so the sign fix restores A exactly
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= r_dz ? '1 : w_quot_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_div_by_zero <= r_is_div && r_dz;
        end
        default: ;
      endcase
    end
  end

  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Scoreboard bench for muldiv_unit (signed and unsigned-only builds)
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic         i_hi_we = 1'b0;
  logic         i_lo_we = 1'b0;
  logic [1:0]   i_op = 2'b00;
  logic [W-1:0] i_data_A = '0;
  logic [W-1:0] i_data_B = '0;

  logic         s_busy, s_done, s_dz;
  logic [W-1:0] s_hi, s_lo;
  logic         u_busy, u_done, u_dz;
  logic [W-1:0] u_hi, u_lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t q_s[$];
  exp_t q_u[$];

  muldiv_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_op(i_op),
    .i_data_A(i_data_A), .i_data_B(i_data_B), .i_hi_we(i_hi_we), .i_lo_we(i_lo_we),
    .o_busy(s_busy), .o_done(s_done), .o_div_by_zero(s_dz), .o_hi(s_hi), .o_lo(s_lo)
  );

  muldiv_unit #(.WIDTH(W), .SIGNED_EN(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_op(i_op),
    .i_data_A(i_data_A), .i_data_B(i_data_B), .i_hi_we(i_hi_we), .i_lo_we(i_lo_we),
    .o_busy(u_busy), .o_done(u_done), .o_div_by_zero(u_dz), .o_hi(u_hi), .o_lo(u_lo)
  );

  always #5 clk = ~clk;

  // Reference model built on native 64-bit arithmetic
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input bit sen);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb, q, r;
    bit          sgn;
    sgn  = sen && op[0];
    e.dz = 1'b0;
    sa   = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb   = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    if (!op[1]) begin
      p    = sgn ? 64'(sa * sb) : ({32'd0, a} * {32'd0, b});
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.lo = '1;
      e.hi = a;
      e.dz = 1'b1;
    end else begin
      q    = sa / sb;
      r    = sa % sb;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end
    return e;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit lo_we, input bit disturb);
    logic [W-1:0] hi0, lo0;
    int           k, busy_n;
    bit           leak;
    exp_t         es, eu;
    @(negedge clk);
    k = 0;
    while ((s_busy || s_done) && k < 50) begin
      @(negedge clk);
      k++;
    end
    hi0 = s_hi;
    lo0 = s_lo;
    q_s.push_back(model(op, a, b, 1'b1));
    q_u.push_back(model(op, a, b, 1'b0));
    i_op = op; i_data_A = a; i_data_B = b; i_start = 1'b1; i_lo_we = lo_we;
    @(posedge clk); #1;
    i_start = 1'b0; i_lo_we = 1'b0; i_data_A = ~a; i_data_B = ~b;
    k = 0; busy_n = 0; leak = 1'b0;
    while (!s_done && k < 40) begin
      if (s_busy) busy_n++;
      if (s_hi !== hi0 || s_lo !== lo0) leak = 1'b1;
      if (disturb && k == 5) begin
        i_start = 1'b1; i_hi_we = 1'b1; i_lo_we = 1'b1; i_op = ~op;
      end
      if (disturb && k == 6) begin
        i_start = 1'b0; i_hi_we = 1'b0; i_lo_we = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (!s_done || k != W + 1)
      begin errors++; $display("FAIL latency: done=%b after %0d cycles, expected done after %0d", s_done, k, W + 1); end
    checks++;
    if (busy_n != W + 1)
      begin errors++; $display("FAIL busy_len: busy for %0d cycles, expected %0d", busy_n, W + 1); end
    checks++;
    if (leak)
      begin errors++; $display("FAIL hilo_hold: HI/LO changed before completion (start HI=%h LO=%h)", hi0, lo0); end
    es = q_s.pop_front();
    eu = q_u.pop_front();
    checks++;
    if (s_hi !== es.hi || s_lo !== es.lo || s_dz !== es.dz)
      begin errors++; $display("FAIL signed_result op=%b A=%h B=%h: got HI=%h LO=%h dz=%b, expected HI=%h LO=%h dz=%b",
                               op, a, b, s_hi, s_lo, s_dz, es.hi, es.lo, es.dz); end
    checks++;
    if (u_done !== 1'b1 || u_hi !== eu.hi || u_lo !== eu.lo || u_dz !== eu.dz)
      begin errors++; $display("FAIL unsigned_result op=%b A=%h B=%h: got done=%b HI=%h LO=%h dz=%b, expected done=1 HI=%h LO=%h dz=%b",
                               op, a, b, u_done, u_hi, u_lo, u_dz, eu.hi, eu.lo, eu.dz); end
    // In DONE a write enable must be ignored and the done pulse must end
    if (disturb) begin
      i_hi_we = 1'b1; i_data_A = 32'hA5A5_A5A5;
    end
    @(posedge clk); #1;
    i_hi_we = 1'b0;
    checks++;
    if (s_done !== 1'b0 || s_hi !== es.hi)
      begin errors++; $display("FAIL done_pulse: done=%b HI=%h, expected done=0 HI=%h", s_done, s_hi, es.hi); end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({s_busy, s_done, s_dz} !== 3'b000)
      begin errors++; $display("FAIL reset_flags: busy/done/dz=%b, expected 000", {s_busy, s_done, s_dz}); end
    checks++;
    if (s_hi !== '0 || s_lo !== '0 || u_hi !== '0 || u_lo !== '0)
      begin errors++; $display("FAIL reset_hilo: HI=%h LO=%h uHI=%h uLO=%h, expected all zero", s_hi, s_lo, u_hi, u_lo); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (s_busy !== 1'b0 || s_done !== 1'b0)
      begin errors++; $display("FAIL idle_after_reset: busy=%b done=%b, expected 0 0", s_busy, s_done); end
  endtask

  task automatic test_mult();
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checks++;
    if (s_hi !== 32'hFFFF_FFFE || s_lo !== 32'h0000_0001)
      begin errors++; $display("FAIL multu_max: got HI=%h LO=%h, expected HI=fffffffe LO=00000001", s_hi, s_lo); end
    run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0);
    checks++;
    if (s_hi !== 32'hFFFF_FFFF || s_lo !== 32'hFFFF_FFF1)
      begin errors++; $display("FAIL mult_neg: got HI=%h LO=%h, expected HI=ffffffff LO=fffffff1", s_hi, s_lo); end
    checks++;
    if (u_hi !== 32'h0000_0004 || u_lo !== 32'hFFFF_FFF1)
      begin errors++; $display("FAIL mult_unsigned_build: got HI=%h LO=%h, expected HI=00000004 LO=fffffff1", u_hi, u_lo); end
    run_op(2'b01, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_op({1'b0, i[0]}, $urandom, $urandom, 1'b0, 1'b0);
  endtask

  task automatic test_div();
    run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    checks++;
    if (s_lo !== 32'hFFFF_FFFD || s_hi !== 32'hFFFF_FFFF)
      begin errors++; $display("FAIL div_neg: got LO=%h HI=%h, expected LO=fffffffd HI=ffffffff", s_lo, s_hi); end
    run_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b0);
    checks++;
    if (s_lo !== 32'd14 || s_hi !== 32'd2)
      begin errors++; $display("FAIL divu_basic: got LO=%0d HI=%0d, expected LO=14 HI=2", s_lo, s_hi); end
    run_op(2'b10, 32'h0000_0064, 32'h0, 1'b0, 1'b0);
    checks++;
    if (s_lo !== 32'hFFFF_FFFF || s_hi !== 32'h0000_0064 || s_dz !== 1'b1)
      begin errors++; $display("FAIL div_by_zero: got LO=%h HI=%h dz=%b, expected LO=ffffffff HI=00000064 dz=1", s_lo, s_hi, s_dz); end
    run_op(2'b00, 32'd3, 32'd4, 1'b0, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checks++;
    if (s_lo !== 32'h8000_0000 || s_hi !== 32'h0 || s_dz !== 1'b0)
      begin errors++; $display("FAIL div_overflow: got LO=%h HI=%h dz=%b, expected LO=80000000 HI=00000000 dz=0", s_lo, s_hi, s_dz); end
    run_op(2'b11, 32'hFFFF_FF9C, 32'h0, 1'b0, 1'b0);
    run_op(2'b11, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      run_op({1'b1, i[0]}, $urandom, (i == 4) ? 32'd1 : ($urandom >> (i * 6)), 1'b0, 1'b0);
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    i_data_A = 32'h1234_5678; i_hi_we = 1'b1;
    @(negedge clk);
    i_hi_we = 1'b0;
    checks++;
    if (s_hi !== 32'h1234_5678 || u_hi !== 32'h1234_5678)
      begin errors++; $display("FAIL mthi: got HI=%h uHI=%h, expected 12345678", s_hi, u_hi); end
    i_data_A = 32'h0BAD_F00D; i_lo_we = 1'b1;
    @(negedge clk);
    i_lo_we = 1'b0;
    checks++;
    if (s_lo !== 32'h0BAD_F00D)
      begin errors++; $display("FAIL mtlo: got LO=%h, expected 0badf00d", s_lo); end
    run_op(2'b00, 32'hDEAD_BEEF, 32'd2, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_op(2'(i), $urandom, $urandom_range(32'd1, 32'hFFFF), 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    bit seen_done;
    @(negedge clk);
    i_op = 2'b00; i_data_A = 32'h0001_2345; i_data_B = 32'h0000_0777; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin i_start = 1'b1; i_lo_we = 1'b1; i_data_A = 32'h7777_7777; end
      if (k == 4) begin i_start = 1'b0; i_lo_we = 1'b0; end
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (s_busy !== 1'b0 || s_done !== 1'b0 || s_dz !== 1'b0)
      begin errors++; $display("FAIL abort_flags: busy=%b done=%b dz=%b, expected 0 0 0", s_busy, s_done, s_dz); end
    checks++;
    if (s_hi !== '0 || s_lo !== '0 || u_hi !== '0 || u_lo !== '0)
      begin errors++; $display("FAIL abort_hilo: HI=%h LO=%h uHI=%h uLO=%h, expected all zero", s_hi, s_lo, u_hi, u_lo); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (s_done || s_busy) seen_done = 1'b1;
    end
    checks++;
    if (seen_done)
      begin errors++; $display("FAIL abort_no_done: activity after aborted op, expected none"); end
    run_op(2'b01, 32'hFFFF_FFF0, 32'h0000_0010, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
